// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// The master side is the environment (producers plus consumer); the slave side is the mux.
interface rr_arb_mux_if #(
    parameter int WIDTH = 64,
    parameter int N     = 4
);
    localparam int SW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      out_sel;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sel
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-input arbitrating multiplexer with a single registered output stage.
// A round-robin (RR=1) or lowest-index-first (RR=0) arbiter picks one valid
// producer whenever the output register is empty or being drained.
module rr_arb_mux #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int RR    = 1
) (
    input  logic            clk,
    input  logic            reset,
    rr_arb_mux_if.slave     bus
);
    localparam int SW = $clog2(N);

    logic [WIDTH-1:0] chan [N];
    logic [SW-1:0]    ptr;
    logic [N-1:0]     grant;
    logic [SW-1:0]    grant_idx;
    logic             grant_any;
    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    next_ptr;
    logic             load_en;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SW-1:0]    out_sel_q;
    int               start;
    int               cand;
    logic [SW-1:0]    cidx;

    // Unpack the flat input bus so channels can be picked by a narrow index.
    for (genvar i = 0; i < N; i++) begin : g_chan
        assign chan[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // The register can take a word when empty or when its word leaves this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    // Scan all channels starting at ptr (or 0 in fixed priority), wrapping
    // explicitly so non-power-of-two N never produces an out-of-range index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sel_data  = '0;
        next_ptr  = '0;
        start     = (RR != 0) ? int'(ptr) : 0;
        cand      = 0;
        cidx      = '0;
        for (int k = 0; k < N; k++) begin
            cand = start + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = SW'(cand);
            if (!grant_any && bus.in_valid[cidx]) begin
                grant_any   = 1'b1;
                grant[cidx] = 1'b1;
                grant_idx   = cidx;
                sel_data    = chan[cidx];
                next_ptr    = (cand == N - 1) ? '0 : SW'(cand + 1);
            end
        end
    end

    // Ready only goes to the granted channel, never during reset or backpressure.
    assign bus.in_ready = (!reset && load_en) ? grant : '0;

    // Output register and round-robin pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            ptr         <= '0;
        end else if (grant_any && load_en) begin
            out_data_q  <= sel_data;
            out_sel_q   <= grant_idx;
            out_valid_q <= 1'b1;
            if (RR != 0) begin
                ptr <= next_ptr;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (N=4 round-robin, N=4 fixed priority,
// N=3 round-robin) see the same stimulus; each has its own reference model
// and scoreboard queue, and a negedge monitor pops words as they leave.
module tb_rr_arb_mux;
    typedef struct {
        int          sel;
        logic [63:0] data;
    } item_t;

    logic        clk;
    logic        reset;
    logic [63:0] ch_data [4];
    logic [3:0]  pend;
    logic [3:0]  granted;
    int          checks;
    int          errors;

    item_t q_a[$];
    item_t q_f[$];
    item_t q_3[$];

    int m_occ [3];
    int m_ptr [3];
    int m_n   [3] = '{4, 4, 3};
    bit m_rr  [3] = '{1'b1, 1'b0, 1'b1};

    int seq_a [6] = '{0, 1, 2, 3, 0, 1};
    int seq_3 [4] = '{0, 1, 2, 0};

    rr_arb_mux_if #(.WIDTH(64), .N(4)) bus_a ();
    rr_arb_mux_if #(.WIDTH(64), .N(4)) bus_f ();
    rr_arb_mux_if #(.WIDTH(64), .N(3)) bus_3 ();

    rr_arb_mux #(.WIDTH(64), .N(4), .RR(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    rr_arb_mux #(.WIDTH(64), .N(4), .RR(0)) dut_f (.clk(clk), .reset(reset), .bus(bus_f));
    rr_arb_mux #(.WIDTH(64), .N(3), .RR(1)) dut_3 (.clk(clk), .reset(reset), .bus(bus_3));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // First valid channel found walking upward from the start index, modulo n.
    function automatic int modelGrant(input logic [3:0] v, input int p, input int n, input bit rr);
        int start;
        start = rr ? p : 0;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (start + k) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic pushItem(input int d, input item_t it);
        case (d)
            0: q_a.push_back(it);
            1: q_f.push_back(it);
            default: q_3.push_back(it);
        endcase
    endtask

    task automatic clearQueue(input int d);
        case (d)
            0: q_a.delete();
            1: q_f.delete();
            default: q_3.delete();
        endcase
    endtask

    // Drive one cycle of inputs, check in_ready against the models, advance models.
    task automatic applyStimulus(input logic [3:0] v, input logic rdy, input logic rst,
                                 output logic [3:0] grant_a);
        logic [3:0] act_ready [3];
        logic [3:0] exp_ready;
        int         g;
        bit         load;
        item_t      it;
        for (int i = 0; i < 4; i++) begin
            bus_a.in_data[i*64 +: 64] = ch_data[i];
            bus_f.in_data[i*64 +: 64] = ch_data[i];
        end
        for (int i = 0; i < 3; i++) begin
            bus_3.in_data[i*64 +: 64] = ch_data[i];
        end
        bus_a.in_valid  = v;
        bus_f.in_valid  = v;
        bus_3.in_valid  = v[2:0];
        bus_a.out_ready = rdy;
        bus_f.out_ready = rdy;
        bus_3.out_ready = rdy;
        reset           = rst;
        #2;
        act_ready[0] = bus_a.in_ready;
        act_ready[1] = bus_f.in_ready;
        act_ready[2] = {1'b0, bus_3.in_ready};
        grant_a = 4'b0000;
        for (int d = 0; d < 3; d++) begin
            exp_ready = 4'b0000;
            if (rst) begin
                m_occ[d] = 0;
                m_ptr[d] = 0;
                clearQueue(d);
            end else begin
                load = (m_occ[d] == 0) || rdy;
                g = modelGrant(v & ((4'b0001 << m_n[d]) - 4'b0001), m_ptr[d], m_n[d], m_rr[d]);
                if (load && g >= 0) begin
                    exp_ready = 4'b0001 << g;
                    it.sel  = g;
                    it.data = ch_data[g];
                    pushItem(d, it);
                    m_occ[d] = 1;
                    if (m_rr[d]) m_ptr[d] = (g + 1) % m_n[d];
                end else if (m_occ[d] != 0 && rdy) begin
                    m_occ[d] = 0;
                end
            end
            if (d == 0) grant_a = exp_ready;
            checkOutput($sformatf("in_ready_dut%0d", d), act_ready[d], exp_ready);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the N=4 round-robin instance.
    always @(negedge clk) begin
        item_t it;
        if (!reset && bus_a.out_valid && bus_a.out_ready) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon_a: unexpected word sel=%0d data=%h, expected none", bus_a.out_sel, bus_a.out_data);
            end else begin
                it = q_a.pop_front();
                checkOutput("mon_a_data", bus_a.out_data, it.data);
                checkOutput("mon_a_sel", 64'(bus_a.out_sel), 64'(it.sel));
            end
        end
    end

    // Scoreboard monitor for the fixed-priority instance.
    always @(negedge clk) begin
        item_t it;
        if (!reset && bus_f.out_valid && bus_f.out_ready) begin
            if (q_f.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon_f: unexpected word sel=%0d data=%h, expected none", bus_f.out_sel, bus_f.out_data);
            end else begin
                it = q_f.pop_front();
                checkOutput("mon_f_data", bus_f.out_data, it.data);
                checkOutput("mon_f_sel", 64'(bus_f.out_sel), 64'(it.sel));
            end
        end
    end

    // Scoreboard monitor for the N=3 round-robin instance.
    always @(negedge clk) begin
        item_t it;
        if (!reset && bus_3.out_valid && bus_3.out_ready) begin
            if (q_3.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL mon_3: unexpected word sel=%0d data=%h, expected none", bus_3.out_sel, bus_3.out_data);
            end else begin
                it = q_3.pop_front();
                checkOutput("mon_3_data", bus_3.out_data, it.data);
                checkOutput("mon_3_sel", 64'(bus_3.out_sel), 64'(it.sel));
            end
        end
    end

    // Directed scenarios first, then a randomized run with occasional resets.
    initial begin
        checks = 0;
        errors = 0;
        pend   = 4'b0000;
        for (int i = 0; i < 4; i++) ch_data[i] = 64'hA0 + 64'(i);

        applyStimulus(4'b0000, 1'b1, 1'b1, granted);
        tick();
        applyStimulus(4'b1111, 1'b1, 1'b1, granted);
        tick();

        $display("[TB] idle after reset");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, granted);
            checkOutput("idle_in_ready", 64'(bus_a.in_ready), 64'h0);
            tick();
            checkOutput("idle_out_valid", 64'(bus_a.out_valid), 64'h0);
            checkOutput("idle_out_data", bus_a.out_data, 64'h0);
            checkOutput("idle_out_sel", 64'(bus_a.out_sel), 64'h0);
        end

        $display("[TB] round-robin with all channels valid");
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0, granted);
            tick();
            checkOutput("rr_sel", 64'(bus_a.out_sel), 64'(seq_a[c]));
            checkOutput("rr_data", bus_a.out_data, 64'hA0 + 64'(seq_a[c]));
            if (c < 4) checkOutput("n3_sel", 64'(bus_3.out_sel), 64'(seq_3[c]));
        end

        $display("[TB] fixed priority with channel 0 idle");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b1110, 1'b1, 1'b0, granted);
            checkOutput("fp_in_ready", 64'(bus_f.in_ready), 64'h2);
            tick();
            checkOutput("fp_sel", 64'(bus_f.out_sel), 64'h1);
        end

        $display("[TB] backpressure");
        ch_data[2] = 64'hDEAD;
        ch_data[3] = 64'h3333;
        applyStimulus(4'b0100, 1'b1, 1'b0, granted);
        tick();
        checkOutput("bp_load_data", bus_a.out_data, 64'hDEAD);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b1011, 1'b0, 1'b0, granted);
            checkOutput("bp_in_ready", 64'(bus_a.in_ready), 64'h0);
            tick();
            checkOutput("bp_hold_data", bus_a.out_data, 64'hDEAD);
            checkOutput("bp_hold_sel", 64'(bus_a.out_sel), 64'h2);
        end
        applyStimulus(4'b1011, 1'b1, 1'b0, granted);
        tick();
        checkOutput("bp_next_sel", 64'(bus_a.out_sel), 64'h3);
        checkOutput("bp_next_data", bus_a.out_data, 64'h3333);

        $display("[TB] reset while a word is held");
        applyStimulus(4'b1111, 1'b0, 1'b1, granted);
        tick();
        checkOutput("rst_out_valid", 64'(bus_a.out_valid), 64'h0);
        checkOutput("rst_out_data", bus_a.out_data, 64'h0);
        applyStimulus(4'b1111, 1'b1, 1'b0, granted);
        tick();
        checkOutput("rst_next_sel", 64'(bus_a.out_sel), 64'h0);
        checkOutput("rst_next_data", bus_a.out_data, ch_data[0]);

        $display("[TB] randomized traffic");
        pend = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] v;
            logic       rdy;
            logic       rst;
            v   = pend | 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) ch_data[i] = {$urandom, $urandom};
            end
            applyStimulus(v, rdy, rst, granted);
            pend = rst ? v : (v & ~granted);
            tick();
        end

        for (int c = 0; c < 4; c++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0, granted);
            tick();
        end
        checkOutput("drain_q_a", 64'(q_a.size()), 64'h0);
        checkOutput("drain_q_f", 64'(q_f.size()), 64'h0);
        checkOutput("drain_q_3", 64'(q_3.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-input arbitrating multiplexer with valid/ready handshakes and a registered output stage. It generalises the plain select-driven datapath mux to N channels. Channel selection is made internally by a round-robin or fixed-priority arbiter instead of an external select. It sits where several producers share one consumer, for example writeback sources merging into a shared result bus or multiple requesters feeding one memory port.

## Interface
- WIDTH, 64, data width per channel in bits
- N, 4, number of input channels (N >= 2)
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with the lowest index winning
- SW, $clog2(N), width of the channel index (derived; not overridden)

- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; combinational; at most one bit set
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word
- out_sel  output  SW  index of the channel that supplied the word in out_data

## Operation
- Transfer rules:
  - An input transfer occurs on channel i when in_valid[i] && in_ready[i] at a clock edge.
  - An output transfer occurs when out_valid && out_ready at a clock edge.
- load_en = !out_valid || out_ready. The output register can accept a new word when it is empty or when its word is being drained in the same cycle.
- Grant (combinational, one-hot or zero):
  - RR=0: the lowest index i with in_valid[i] set.
  - RR=1: search upward from ptr, wrapping from N-1 to 0; the first i with in_valid[i] set wins.
- in_ready[i] = load_en && grant[i] && !reset. in_ready never depends on in_data.
- On an input transfer from channel g:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - If RR=1, ptr <= (g+1) mod N. The wrap must also be correct when N is not a power of two.
- On an output transfer with no input transfer in the same cycle: out_valid <= 0. out_data and out_sel keep their values.
- When out_valid && !out_ready, out_data and out_sel stay stable and every in_ready bit is 0.
- ptr (round-robin start index, SW bits) changes only on an input transfer. When RR=0, ptr is unused and stays at 0.
- Input side, producer obligation: a producer must hold in_valid and in_data until its channel is granted. The block may grant another channel in the meantime; it never locks onto a channel.
- Fairness, RR=1: a channel held valid is granted within N input transfers.
- No data loss or duplication. Each input transfer produces exactly one output transfer, in order.

## Timing
- Reset (reset=1 at an edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready=0 for the whole cycle in which reset is high.
- Reset while a word is held: the word is discarded and is not presented afterwards.
- Latency: an input accepted at edge k appears on out_data/out_valid immediately after edge k. That is one cycle of latency.
- Throughput: one word per cycle while out_ready is held at 1. A drain and a refill in the same cycle are permitted and required.
- Idle: no in_valid bits set and load_en=1 gives in_ready=0 and leaves ptr unchanged.
- Single requester: that requester is granted regardless of ptr.
- Grant to ptr itself: with RR=1, ptr advances to ptr+1 mod N.
- Simultaneous reset and handshakes: reset has priority; no transfer is counted.

## Test plan
- Reset, then hold out_ready=1 and in_valid=4'b0000 for 5 cycles. Required: out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
- RR=1, N=4, in_valid=4'b1111 held, out_ready=1, in_data[i]=64'hA0+i. Required: out_sel sequence 0,1,2,3,0,1 on consecutive cycles with matching data 64'hA0,A1,A2,A3,A0,A1.
- RR=0, N=4, in_valid=4'b1110 held, out_ready=1. Required: out_sel=1 every cycle and in_ready=4'b0010 every cycle.
- Backpressure: accept channel 2 (data 64'hDEAD), then hold out_ready=0 for 3 cycles with in_valid=4'b1011. Required: out_data=64'hDEAD, out_sel=2, in_ready=0 throughout. After out_ready=1, the next word comes from channel 3.
- N=3 wrap (non-power-of-two): RR=1, in_valid=3'b111. Required: grants 0,1,2,0; ptr never takes the value 3.
- Assert reset for 1 cycle while out_valid=1 and out_ready=0. Required: out_valid=0 and out_data=0 on the following cycle, and the next grant with in_valid all set is channel 0.
